axi_lite_slave: RTL and testbench
=================================

# axi_lite_slave

AXI4-Lite responder exposing a bank of `NUM_REGS` 32-bit read/write registers. It is the slave-side counterpart of `axi_lite_master` and sits on the same single-clock AXI4-Lite bus. Write and read channels run independently, with one outstanding transaction per direction. Register contents are readable as a flat vector for downstream logic.

## Interface
- `NUM_REGS`, 4, number of 32-bit registers (1..256); byte offsets 0 .. 4*NUM_REGS-1
- `ADDR_WIDTH`, 32, AWADDR/ARADDR width
- `ACLK` in 1: clock, all logic on rising edge
- `ARESETn` in 1: synchronous reset, active-low (one clock; reset is synchronous and active-low)
- `S_AXI_AWADDR` in ADDR_WIDTH; `S_AXI_AWPROT` in 3 (ignored); `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1
- `S_AXI_WDATA` in 32; `S_AXI_WSTRB` in 4; `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1
- `S_AXI_ARADDR` in ADDR_WIDTH; `S_AXI_ARPROT` in 3 (ignored); `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1
- `S_AXI_RDATA` out 32; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1
- `REGS_OUT` out 32*NUM_REGS: register i is on bits [32i+31:32i]

## Operation
- Reset (ARESETn=0 at an edge): all READY/VALID outputs are 0, BRESP/RRESP/RDATA are 0, all registers are 0, and pending transactions are dropped. This applies mid-transaction.
- Decode: word index = ADDR[ADDR_WIDTH-1:2]. ADDR[1:0] is ignored. Index >= NUM_REGS means out-of-range.
- Write FSM, states `W_IDLE`, `W_RESP`:
  - In W_IDLE, AW and W are accepted independently and in either order, each into its own holding register with a "have" flag.
  - AWREADY = W_IDLE && !have_aw. WREADY = W_IDLE && !have_w. Both are registered.
  - Commit happens on the edge where both address and data are held or being handshaken, including a same-edge AW+W handshake. An in-range commit updates each byte lane whose WSTRB bit is 1 and leaves strobe-0 lanes unchanged. BRESP is OKAY (2'b00) in range. Out of range, no register changes and BRESP is SLVERR (2'b10).
  - The commit sets BVALID=1, clears both have flags, and moves to W_RESP.
  - W_RESP: BVALID and BRESP hold until BREADY=1. On that edge BVALID=0 and the FSM returns to W_IDLE.
- Read FSM, states `R_IDLE`, `R_RESP`:
  - ARREADY = R_IDLE (registered).
  - On the AR handshake, RDATA gets the register value (0 if out of range) and RRESP gets OKAY or SLVERR. RVALID=1 and the FSM moves to R_RESP.
  - RDATA, RRESP and RVALID are stable until RREADY=1. On that edge RVALID=0 and the FSM returns to R_IDLE.
- Read/write collision: if the AR handshake and a write commit to the same register happen on the same edge, RDATA returns the pre-write value.

## Timing
- AWREADY, WREADY and ARREADY are 1 in the first cycle after reset release.
- Write latency: BVALID is high in the cycle after the later of the AW and W handshakes.
- Read latency: RVALID is high in the cycle after the AR handshake.
- AWREADY and WREADY go low in the cycle after their own handshake. Both return high in the cycle after the B handshake.
- ARREADY returns high in the cycle after the R handshake.
- Peak throughput is one write per 2 cycles and one read per 2 cycles, with both directions running concurrently.
- VALID outputs never depend combinationally on READY inputs. There are no combinational input-to-output paths.
- REGS_OUT reflects a commit in the cycle after the commit edge.

## Structure
- Package `axi_lite_pkg` holds:
  - `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10
  - `ADDR_LSB` = 2
  - the write-FSM and read-FSM state encodings
- Sub-module `axi_lite_regfile` provides the register storage:
  - a write port with index, 32-bit data, 4-bit byte strobe and enable
  - a combinational read port by index
  - the flat `REGS_OUT` vector
  - synchronous active-low clear
- The top level holds both FSMs, the AW/W holding registers, address decode and the response registers.

## Test plan
- Reset: hold ARESETn=0 for 3 cycles, then release. All VALIDs are 0 during reset, the three READYs are 1 on the first cycle after release, and a read of 0x0 returns 0x00000000 with OKAY.
- AW+W same cycle: write 0x12345678 to 0x4 with WSTRB=4'hF, then read 0x4. BVALID appears one cycle after the handshake with BRESP=OKAY, RDATA=0x12345678 and RRESP=OKAY.
- W three cycles before AW, partial strobe: register 0x8 holds 0x11223344; write 0xAABBCCDD with WSTRB=4'b0011. The register becomes 0x1122CCDD, and BVALID appears one cycle after the AW handshake.
- Backpressure: hold BREADY=0 for 5 cycles after BVALID, with a new AW presented. BVALID stays 1, AWREADY stays 0 and the new AW is not accepted. The new AW is accepted the cycle after BREADY=1.
- Out-of-range with NUM_REGS=4: writing 0xDEADBEEF to 0x40 gives BRESP=SLVERR with all registers unchanged. Reading 0x40 gives RDATA=0 and RRESP=SLVERR.
- Reset mid-transaction: assert ARESETn=0 while BVALID=1 and RVALID=1. Both are 0 after the edge, and on release all registers read 0 and all READYs return to 1.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave.
//   RESP_OKAY / RESP_SLVERR : BRESP/RRESP encodings
//   ADDR_LSB                : first address bit of the word index
//   w_state_t / r_state_t   : write and read channel FSM encodings
//   idx_width()             : register-index width for a given bank size
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ADDR_LSB = 2;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    // A single-register bank still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Register storage for the AXI4-Lite slave.
//   ACLK, ARESETn : clock, synchronous active-low clear of all registers
//   wr_en, wr_idx, wr_data, wr_strb : byte-strobed write port
//   rd_idx, rd_data                 : combinational read port
//   regs_out                        : flat view, register i on [32i+31:32i]
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = idx_width(NUM_REGS)
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_strb,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [31:0]              rd_data,
    output logic [32*NUM_REGS-1:0]   regs_out
);

    logic [31:0] regs_q [NUM_REGS];

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Compare-based select keeps indices beyond a non-power-of-two bank
    // from ever addressing outside the array; they read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[32*g +: 32] = regs_q[g];
    end

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
//   ACLK, ARESETn          : clock, synchronous active-low reset
//   S_AXI_AW* / S_AXI_W*   : write address / data channels (PROT ignored)
//   S_AXI_B*               : write response channel
//   S_AXI_AR* / S_AXI_R*   : read address / data channels (PROT ignored)
//   REGS_OUT               : flat register contents, register i on [32i+31:32i]
//
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W (either order); commit once both held
//   W_RESP | BVALID high, waiting for BREADY
// Read FSM
//   state  | meaning
//   R_IDLE | ARREADY high, waiting for an address
//   R_RESP | RVALID high, waiting for RREADY
module axi_lite_slave
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]   REGS_OUT
);

    localparam int IDX_W  = idx_width(NUM_REGS);
    localparam int WORD_W = ADDR_WIDTH - ADDR_LSB;
    localparam logic [WORD_W-1:0] NUM_REGS_WORD = WORD_W'(NUM_REGS);

    // ---------------- write channel state ----------------
    w_state_t              w_state, w_state_n;
    logic                  have_aw, have_aw_n;
    logic                  have_w, have_w_n;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_n;
    logic [31:0]           w_data_q, w_data_n;
    logic [3:0]            w_strb_q, w_strb_n;
    logic                  awready_q, awready_n;
    logic                  wready_q, wready_n;
    logic                  bvalid_q, bvalid_n;
    logic [1:0]            bresp_q, bresp_n;

    // ---------------- read channel state ----------------
    r_state_t              r_state, r_state_n;
    logic                  arready_q, arready_n;
    logic                  rvalid_q, rvalid_n;
    logic [31:0]           rdata_q, rdata_n;
    logic [1:0]            rresp_q, rresp_n;

    // ---------------- decode / regfile hookup ----------------
    logic [WORD_W-1:0]     wr_word, rd_word;
    logic                  wr_in_range, rd_in_range;
    logic                  wr_en;
    logic [31:0]           rf_rd_data;
    logic                  aw_hs, w_hs, ar_hs;
    logic                  unused_bits;

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID  && wready_q;
    assign ar_hs = S_AXI_ARVALID && arready_q;

    // Decode uses the "next" holding value so a same-edge handshake commits
    // straight from the bus without a wasted cycle.
    assign wr_word     = aw_addr_n[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_word     = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_in_range = (wr_word < NUM_REGS_WORD);
    assign rd_in_range = (rd_word < NUM_REGS_WORD);

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           aw_addr_n[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    axi_lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .wr_en    (wr_en),
        .wr_idx   (wr_word[IDX_W-1:0]),
        .wr_data  (w_data_n),
        .wr_strb  (w_strb_n),
        .rd_idx   (rd_word[IDX_W-1:0]),
        .rd_data  (rf_rd_data),
        .regs_out (REGS_OUT)
    );

    // ---------------- write FSM ----------------
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state   <= W_IDLE;
            have_aw   <= 1'b0;
            have_w    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state   <= w_state_n;
            have_aw   <= have_aw_n;
            have_w    <= have_w_n;
            aw_addr_q <= aw_addr_n;
            w_data_q  <= w_data_n;
            w_strb_q  <= w_strb_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
        end
    end

    always_comb begin
        w_state_n = w_state;
        have_aw_n = have_aw;
        have_w_n  = have_w;
        aw_addr_n = aw_addr_q;
        w_data_n  = w_data_q;
        w_strb_n  = w_strb_q;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        wr_en     = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs) begin
                    have_aw_n = 1'b1;
                    aw_addr_n = S_AXI_AWADDR;
                end
                if (w_hs) begin
                    have_w_n = 1'b1;
                    w_data_n = S_AXI_WDATA;
                    w_strb_n = S_AXI_WSTRB;
                end
                if (have_aw_n && have_w_n) begin
                    wr_en     = wr_in_range;
                    bvalid_n  = 1'b1;
                    bresp_n   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    have_aw_n = 1'b0;
                    have_w_n  = 1'b0;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                    w_state_n = W_RESP;
                end else begin
                    awready_n = !have_aw_n;
                    wready_n  = !have_w_n;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: begin
                w_state_n = W_IDLE;
            end
        endcase
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state   <= r_state_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
        end
    end

    // The regfile read is combinational from the current register contents,
    // so a read colliding with a same-edge write captures the old value.
    always_comb begin
        r_state_n = r_state;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ar_hs) begin
                    rdata_n   = rd_in_range ? rf_rd_data : 32'h0;
                    rresp_n   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rvalid_n  = 1'b1;
                    arready_n = 1'b0;
                    r_state_n = R_RESP;
                end
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: begin
                r_state_n = R_IDLE;
            end
        endcase
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed self-checking bench for axi_lite_slave (NUM_REGS=4).
module tb_axi_lite_slave;

    localparam int NUM_REGS   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                   ACLK = 1'b0;
    logic                   ARESETn = 1'b0;
    logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR = '0;
    logic [2:0]             S_AXI_AWPROT = '0;
    logic                   S_AXI_AWVALID = 1'b0;
    logic                   S_AXI_AWREADY;
    logic [31:0]            S_AXI_WDATA = '0;
    logic [3:0]             S_AXI_WSTRB = '0;
    logic                   S_AXI_WVALID = 1'b0;
    logic                   S_AXI_WREADY;
    logic [1:0]             S_AXI_BRESP;
    logic                   S_AXI_BVALID;
    logic                   S_AXI_BREADY = 1'b0;
    logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR = '0;
    logic [2:0]             S_AXI_ARPROT = '0;
    logic                   S_AXI_ARVALID = 1'b0;
    logic                   S_AXI_ARREADY;
    logic [31:0]            S_AXI_RDATA;
    logic [1:0]             S_AXI_RRESP;
    logic                   S_AXI_RVALID;
    logic                   S_AXI_RREADY = 1'b0;
    logic [32*NUM_REGS-1:0] REGS_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    axi_lite_slave #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .REGS_OUT      (REGS_OUT)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // AW and W presented together; returns one cycle after the later handshake.
    task automatic write_issue(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int t = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        while (!(aw_done && w_done) && t < 20) begin
            bit aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            bit w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            t++;
            if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (w_hs)  begin w_done  = 1; S_AXI_WVALID  = 1'b0; end
        end
        chk("write_hs_done", {aw_done, w_done}, 2'b11);
        chk("bvalid_latency", S_AXI_BVALID, 1'b1);
        resp = S_AXI_BRESP;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
    endtask

    task automatic write_ack();
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        chk("bvalid_drop", S_AXI_BVALID, 1'b0);
        chk("aw_w_ready_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    endtask

    task automatic read_issue(input logic [31:0] addr);
        bit done = 0;
        int t = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!done && t < 20) begin
            bit hs = S_AXI_ARVALID && S_AXI_ARREADY;
            tick();
            t++;
            if (hs) done = 1;
        end
        S_AXI_ARVALID = 1'b0;
        chk("ar_hs_done", done, 1'b1);
        chk("rvalid_latency", S_AXI_RVALID, 1'b1);
    endtask

    task automatic read_ack();
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        chk("rvalid_drop", S_AXI_RVALID, 1'b0);
        chk("arready_back", S_AXI_ARREADY, 1'b1);
    endtask

    task automatic read_expect(input string tag, input logic [31:0] addr,
                               input logic [31:0] exp_data, input logic [1:0] exp_resp);
        read_issue(addr);
        chk({tag, "_rdata"}, S_AXI_RDATA, exp_data);
        chk({tag, "_rresp"}, S_AXI_RRESP, exp_resp);
        read_ack();
    endtask

    initial begin
        logic [1:0] resp;

        // ---- reset ----
        ARESETn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        end
        ARESETn = 1'b1;
        tick();
        chk("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        chk("rst_regs", REGS_OUT, 128'h0);
        read_expect("rst_read0", 32'h0, 32'h0, OKAY);

        // ---- AW+W same cycle ----
        write_issue(32'h4, 32'h12345678, 4'hF, resp);
        chk("w4_bresp", resp, OKAY);
        write_ack();
        read_expect("r4", 32'h4, 32'h12345678, OKAY);

        // ---- W three cycles before AW, partial strobe ----
        write_issue(32'h8, 32'h11223344, 4'hF, resp);
        write_ack();
        S_AXI_WDATA  = 32'hAABBCCDD;
        S_AXI_WSTRB  = 4'b0011;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        chk("wfirst_wready_low", S_AXI_WREADY, 1'b0);
        chk("wfirst_no_b", S_AXI_BVALID, 1'b0);
        tick();
        tick();
        chk("wfirst_no_b2", S_AXI_BVALID, 1'b0);
        chk("wfirst_awready", S_AXI_AWREADY, 1'b1);
        S_AXI_AWADDR  = 32'h8;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("wfirst_bvalid", S_AXI_BVALID, 1'b1);
        chk("wfirst_bresp", S_AXI_BRESP, OKAY);
        chk("wfirst_regs_out", REGS_OUT[95:64], 32'h1122CCDD);
        write_ack();
        read_expect("r8", 32'h8, 32'h1122CCDD, OKAY);

        // ---- B backpressure with a new AW waiting ----
        write_issue(32'hC, 32'hCAFEF00D, 4'hF, resp);
        chk("wc_bresp", resp, OKAY);
        S_AXI_AWADDR  = 32'h0;
        S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_bvalid_hold", S_AXI_BVALID, 1'b1);
            chk("bp_awready_low", S_AXI_AWREADY, 1'b0);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        chk("bp_bvalid_drop", S_AXI_BVALID, 1'b0);
        chk("bp_awready_back", S_AXI_AWREADY, 1'b1);
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("bp_aw_accepted", S_AXI_AWREADY, 1'b0);
        chk("bp_no_b_yet", S_AXI_BVALID, 1'b0);
        S_AXI_WDATA  = 32'h55AA55AA;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        chk("bp_w_bvalid", S_AXI_BVALID, 1'b1);
        write_ack();
        read_expect("r0", 32'h0, 32'h55AA55AA, OKAY);
        read_expect("rc_lowbits", 32'hF, 32'hCAFEF00D, OKAY);

        // ---- out of range ----
        write_issue(32'h40, 32'hDEADBEEF, 4'hF, resp);
        chk("oor_bresp", resp, SLVERR);
        write_ack();
        chk("oor_regs", REGS_OUT, 128'hCAFEF00D_1122CCDD_12345678_55AA55AA);
        read_expect("oor_read", 32'h40, 32'h0, SLVERR);
        read_expect("oor_read_idx4", 32'h10, 32'h0, SLVERR);

        // ---- read/write collision on one register ----
        S_AXI_AWADDR  = 32'h4;
        S_AXI_WDATA   = 32'h0BADF00D;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = 32'h4;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        chk("coll_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        chk("coll_rdata_old", S_AXI_RDATA, 32'h12345678);
        chk("coll_regs_new", REGS_OUT[63:32], 32'h0BADF00D);
        write_ack();
        read_ack();
        read_expect("coll_after", 32'h4, 32'h0BADF00D, OKAY);

        // ---- reset mid-transaction ----
        write_issue(32'h0, 32'h77777777, 4'hF, resp);
        read_issue(32'h8);
        chk("mid_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        ARESETn = 1'b0;
        tick();
        chk("mid_rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        chk("mid_rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        chk("mid_rst_resp", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'h0);
        chk("mid_rst_regs", REGS_OUT, 128'h0);
        ARESETn = 1'b1;
        tick();
        chk("mid_rel_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        for (int i = 0; i < NUM_REGS; i++) begin
            read_expect("mid_rel_read", 32'(4 * i), 32'h0, OKAY);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
